// File: rtl/sub_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sub_serial_if.sv
// Request/result bundle for sub_serial.
// The overflow flag v exists only when SUB_SERIAL_OVF_EN is defined.
interface sub_serial_if
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             busy;
  logic             done;
`ifdef SUB_SERIAL_OVF_EN
  logic             v;
`endif

`ifdef SUB_SERIAL_OVF_EN
  modport master (output start, a, b, input d, bout, zero, busy, done, v);
  modport slave  (input start, a, b, output d, bout, zero, busy, done, v);
`else
  modport master (output start, a, b, input d, bout, zero, busy, done);
  modport slave  (input start, a, b, output d, bout, zero, busy, done);
`endif

endinterface

// File: rtl/sub_serial_one_bit.sv
// Combinational one-bit full subtractor: result = a - b - bin.
module sub_one_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic bout,
  output logic result
);

  assign result = a ^ b ^ bin;
  assign bout   = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: d = a - b, one bit per clock, LSB first.
// Optional overflow flag v is built when SUB_SERIAL_OVF_EN is defined.
module sub_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_serial_if.slave  bus
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_zero;
`ifdef SUB_SERIAL_OVF_EN
  logic             r_v;
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_diff;
  logic             w_bnext;
  logic [WIDTH-1:0] w_d_final;

  // Start is honoured only when no subtraction is in flight.
  assign w_accept  = bus.start && ((r_state == IDLE) || (r_state == DONE));
  // Last bit step: the operand shift registers hold their MSBs at bit 0.
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  assign w_d_final = {w_diff, r_res[WIDTH-1:1]};

  sub_one_bit u_bit (
    .a      (r_a[0]),
    .b      (r_b[0]),
    .bin    (r_borrow),
    .bout   (w_bnext),
    .result (w_diff)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and borrow/counter tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_d_final;
      r_borrow <= w_bnext;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers update only on the final bit step and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b1;
`ifdef SUB_SERIAL_OVF_EN
      r_v    <= 1'b0;
`endif
    end else if (w_last) begin
      r_d    <= w_d_final;
      r_bout <= w_bnext;
      r_zero <= (w_d_final == '0);
`ifdef SUB_SERIAL_OVF_EN
      // Overflow: operand signs differ and the result sign differs from a.
      r_v    <= (r_a[0] != r_b[0]) && (w_diff != r_a[0]);
`endif
    end
  end

  assign bus.d    = r_d;
  assign bus.bout = r_bout;
  assign bus.zero = r_zero;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
`ifdef SUB_SERIAL_OVF_EN
  assign bus.v    = r_v;
`endif

endmodule
